// File: rtl/des_key_schedule.sv
// DES round-key generator: PC-1 on start, per-round C/D rotation, PC-2 per
// subkey, streamed one subkey per round over a valid/ready handshake in
// either encrypt (K1..KN) or decrypt (KN..K1) order.
module des_key_schedule #(
    parameter int          NUM_ROUNDS  = 16,
    parameter logic [15:0] SHIFT_SCHED = 16'h8103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iKs,
    input  logic        decrypt,
    input  logic [63:0] key64,
    output logic [47:0] subkey48,
    output logic        subkeyValid,
    input  logic        subkeyReady,
    output logic [3:0]  roundIdx,
    output logic        busy,
    output logic        fKs
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_OUT} state_t;

    // DES bit numbers (1-based, bit 1 = MSB) selected for each output position
    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic        dec_q, dec_d;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;
    logic        fks_q, fks_d;

    logic [55:0] pc1_key;
    logic [47:0] pc2_cd;
    logic        handshake;
    logic        is_last;
    logic [3:0]  idx_inc;

    // Rotate each 28-bit half left by 1 or 2, wrapping within the half
    function automatic logic [55:0] rot_l(input logic [55:0] cd, input logic by_one);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (by_one) return {c[26:0], c[27], d[26:0], d[27]};
        else        return {c[25:0], c[27:26], d[25:0], d[27:26]};
    endfunction

    // Rotate each 28-bit half right by 1 or 2 (undoes rot_l)
    function automatic logic [55:0] rot_r(input logic [55:0] cd, input logic by_one);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (by_one) return {c[0], c[27:1], d[0], d[27:1]};
        else        return {c[1:0], c[27:2], d[1:0], d[27:2]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            localparam int SRC = 64 - PC1_TBL[gi];
            assign pc1_key[55-gi] = key64[SRC];
        end
        // PC-2 operates on the next CD value so the subkey register updates
        // together with the rotation and back-to-back subkeys need no bubble
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            localparam int SRC = 56 - PC2_TBL[gi];
            assign pc2_cd[47-gi] = cd_d[SRC];
        end
    endgenerate

    assign handshake = (state_q == ST_OUT) && valid_q && subkeyReady;
    assign is_last   = dec_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX);
    assign idx_inc   = idx_q + 4'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (iKs) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_OUT;
            ST_OUT:  if (handshake && is_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // CD register and mode latch next values
    always_comb begin
        cd_d  = cd_q;
        dec_d = dec_q;
        case (state_q)
            ST_IDLE: begin
                if (iKs) begin
                    dec_d = decrypt;
                    cd_d  = decrypt ? pc1_key : rot_l(pc1_key, SHIFT_SCHED[0]);
                end
            end
            ST_OUT: begin
                if (handshake && !is_last) begin
                    if (dec_q) cd_d = rot_r(cd_q, SHIFT_SCHED[idx_q]);
                    else       cd_d = rot_l(cd_q, SHIFT_SCHED[idx_inc]);
                end
            end
            default: ;
        endcase
    end

    // Output-side next values: subkey, valid, round index, done pulse
    always_comb begin
        subkey_d = subkey_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        fks_d    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                subkey_d = pc2_cd;
                valid_d  = 1'b1;
                idx_d    = dec_q ? LAST_IDX : 4'd0;
            end
            ST_OUT: begin
                if (handshake) begin
                    if (is_last) begin
                        valid_d = 1'b0;
                        fks_d   = 1'b1;
                    end else begin
                        subkey_d = pc2_cd;
                        idx_d    = dec_q ? (idx_q - 4'd1) : idx_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_q     <= '0;
            dec_q    <= 1'b0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            fks_q    <= 1'b0;
        end else begin
            cd_q     <= cd_d;
            dec_q    <= dec_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            fks_q    <= fks_d;
        end
    end

    assign subkey48    = subkey_q;
    assign subkeyValid = valid_q;
    assign roundIdx    = idx_q;
    assign fKs         = fks_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_des_key_schedule.sv
// Testbench for des_key_schedule: randomized keys and backpressure checked
// against a table-driven DES key-schedule model using DES bit numbering.
module tb_des_key_schedule;

    localparam logic [15:0] SCHED   = 16'h8103;
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

    localparam int PC1_T [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        iKs, decrypt, subkeyReady;
    logic [63:0] key64;
    logic [47:0] subkey48;
    logic        subkeyValid, busy, fKs;
    logic [3:0]  roundIdx;

    logic        iks_b, ready_b;
    logic [63:0] key_b;
    logic [47:0] sk_b;
    logic        valid_b, busy_b, fks_b;
    logic [3:0]  idx_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [47:0] ref_k [16];

    always #5 clk = ~clk;

    des_key_schedule #(.NUM_ROUNDS(16), .SHIFT_SCHED(SCHED)) dut (
        .clk(clk), .rst(rst), .iKs(iKs), .decrypt(decrypt), .key64(key64),
        .subkey48(subkey48), .subkeyValid(subkeyValid), .subkeyReady(subkeyReady),
        .roundIdx(roundIdx), .busy(busy), .fKs(fKs)
    );

    des_key_schedule #(.NUM_ROUNDS(4), .SHIFT_SCHED(SCHED)) dut4 (
        .clk(clk), .rst(rst), .iKs(iks_b), .decrypt(1'b0), .key64(key_b),
        .subkey48(sk_b), .subkeyValid(valid_b), .subkeyReady(ready_b),
        .roundIdx(idx_b), .busy(busy_b), .fKs(fks_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Round r key from the cumulative shift count: C_r bit i = C_0 bit (i+t) mod 28
    task automatic compute_ref(input logic [63:0] key);
        bit c0 [28];
        bit d0 [28];
        bit cd [56];
        int t;
        logic [47:0] k;
        for (int i = 0; i < 28; i++) begin
            c0[i] = key[64 - PC1_T[i]];
            d0[i] = key[64 - PC1_T[28 + i]];
        end
        t = 0;
        for (int r = 1; r <= 16; r++) begin
            t += SCHED[r-1] ? 1 : 2;
            for (int i = 0; i < 28; i++) begin
                cd[i]      = c0[(i + t) % 28];
                cd[28 + i] = d0[(i + t) % 28];
            end
            k = '0;
            for (int j = 0; j < 48; j++) k[47 - j] = cd[PC2_T[j] - 1];
            ref_k[r-1] = k;
        end
    endtask

    // One 16-round run. rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic run_a(input logic [63:0] key, input logic dec, input int rdy_mode,
                         input bit inject, input bit rst5, input bit kat,
                         input logic [47:0] first_exp, input logic [47:0] last_exp);
        int  got;
        int  cyc;
        int  idx;
        bit  rdy;
        compute_ref(key);
        key64 = key; decrypt = dec; iKs = 1'b1;
        @(posedge clk); #1;
        iKs = 1'b0;
        key64 = {$urandom, $urandom};
        decrypt = ~dec;
        subkeyReady = 1'b1;
        check("load_busy", busy, 1);
        check("load_valid", subkeyValid, 0);
        got = 0; cyc = 0;
        while (got < 16 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            idx = dec ? 15 - got : got;
            check("valid", subkeyValid, 1);
            check("busy", busy, 1);
            check("fks_early", fKs, 0);
            check("subkey", subkey48, ref_k[idx]);
            check("round_idx", roundIdx, idx);
            if (kat && got == 0)  check("kat_first", subkey48, first_exp);
            if (kat && got == 15) check("kat_last", subkey48, last_exp);
            if (rst5 && got == 4) begin
                rst = 1'b1; #1;
                check("rst_valid", subkeyValid, 0);
                check("rst_busy", busy, 0);
                check("rst_fks", fKs, 0);
                rst = 1'b0;
                subkeyReady = 1'b0;
                $display("[TB] reset mid-run at subkey 5");
                return;
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 1);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            subkeyReady = rdy;
            if (inject && got == 5) begin
                iKs = 1'b1;
                key64 = {$urandom, $urandom};
            end else begin
                iKs = 1'b0;
            end
            if (rdy) begin
                $display("[TB] dec=%0d round=%0d subkey=%h", dec, idx + 1, subkey48);
                got++;
            end
        end
        if (got < 16) check("timeout", got, 16);
        if (inject) iKs = 1'b1;
        @(posedge clk); #1;
        iKs = 1'b0;
        subkeyReady = 1'b0;
        check("fks_pulse", fKs, 1);
        check("end_valid", subkeyValid, 0);
        check("end_busy", busy, 0);
        @(posedge clk); #1;
        check("fks_once", fKs, 0);
        check("idle_busy", busy, 0);
    endtask

    // Short run on the 4-round instance; must match K1..K4 of the full schedule
    task automatic run_b(input logic [63:0] key);
        compute_ref(key);
        key_b = key; iks_b = 1'b1; ready_b = 1'b1;
        @(posedge clk); #1;
        iks_b = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(posedge clk); #1;
            check("b_valid", valid_b, 1);
            check("b_subkey", sk_b, ref_k[g]);
            check("b_idx", idx_b, g);
            check("b_fks_early", fks_b, 0);
            $display("[TB] n4 round=%0d subkey=%h", g + 1, sk_b);
        end
        @(posedge clk); #1;
        check("b_fks", fks_b, 1);
        check("b_end_valid", valid_b, 0);
        check("b_end_busy", busy_b, 0);
        ready_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; iKs = 1'b0; decrypt = 1'b0; subkeyReady = 1'b0; key64 = '0;
        iks_b = 1'b0; ready_b = 1'b0; key_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_subkey", subkey48, 0);
        check("rst_valid0", subkeyValid, 0);
        check("rst_idx", roundIdx, 0);
        check("rst_busy0", busy, 0);
        check("rst_fks0", fKs, 0);
        check("rst_b_valid", valid_b, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_a(KAT_KEY, 1'b0, 0, 1'b0, 1'b0, 1'b1, KAT_K1, KAT_K16);
        run_a(KAT_KEY, 1'b1, 0, 1'b0, 1'b0, 1'b1, KAT_K16, KAT_K1);
        run_a({$urandom, $urandom}, 1'b0, 1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_a(KAT_KEY, 1'b0, 0, 1'b1, 1'b0, 1'b1, KAT_K1, KAT_K16);
        run_a({$urandom, $urandom}, 1'b0, 0, 1'b0, 1'b1, 1'b0, '0, '0);
        run_a(KAT_KEY, 1'b0, 2, 1'b0, 1'b0, 1'b1, KAT_K1, KAT_K16);
        for (int n = 0; n < 4; n++) begin
            run_a({$urandom, $urandom}, n[0], 2, n[1], 1'b0, 1'b0, '0, '0);
        end
        run_b(KAT_KEY);
        run_b({$urandom, $urandom});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
